// File: rtl/tile_hit_judge.sv
// Tile hit judge: synchronizes the player keys, judges presses against the tile
// row latched for each window, and keeps score, miss count and game-over.
module tile_hit_judge #(
  parameter int SCORE_W    = 8,
  parameter int MAX_MISSES = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               tick,
  input  logic [3:0]         row,
  input  logic [3:0]         key_n,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               hit,
  output logic               miss,
  output logic               game_over,
  output logic [3:0]         target
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [4:0] MISS_LIMIT = 5'(MAX_MISSES);
  localparam logic [SCORE_W+2:0] SCORE_TOP = (SCORE_W+3)'({SCORE_W{1'b1}});

  function automatic logic [2:0] count_ones(input logic [3:0] v);
    count_ones = 3'd0;
    for (int i = 0; i < 4; i++) begin
      count_ones = count_ones + {2'b00, v[i]};
    end
  endfunction

  state_t             state_r, state_s;
  logic [3:0]         sync1_r, sync2_r, prev_r, press_r;
  logic               tick_d_r;
  logic [3:0]         mask_r, mask_s;
  logic [3:0]         target_r, target_s;
  logic [SCORE_W-1:0] score_r, score_s;
  logic [3:0]         misses_r, misses_s;
  logic               hit_r, hit_s;
  logic               miss_r, miss_s;
  logic               game_over_r;
  logic [3:0]         good_s, bad_s;
  logic               close_s;
  logic [SCORE_W+2:0] score_sum_s;
  logic [4:0]         miss_sum_s;

  // key synchronizer, press edge register and tick delay (keys are active-low)
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1_r  <= 4'b1111;
      sync2_r  <= 4'b1111;
      prev_r   <= 4'b1111;
      press_r  <= 4'b0000;
      tick_d_r <= 1'b0;
    end else begin
      sync1_r  <= key_n;
      sync2_r  <= sync1_r;
      prev_r   <= sync2_r;
      press_r  <= ~sync2_r & prev_r;
      tick_d_r <= tick;
    end
  end

  // judging: a press in the tick_d cycle still counts against the closing window
  always_comb begin
    state_s     = state_r;
    mask_s      = mask_r;
    target_s    = target_r;
    score_s     = score_r;
    misses_s    = misses_r;
    hit_s       = 1'b0;
    miss_s      = 1'b0;
    good_s      = press_r & target_r & ~mask_r;
    bad_s       = press_r & ~good_s;
    close_s     = tick_d_r && (target_r != 4'b0000) && ((mask_r | good_s) != target_r);
    score_sum_s = (SCORE_W+3)'(score_r) + (SCORE_W+3)'(count_ones(good_s));
    miss_sum_s  = {1'b0, misses_r} + {4'b0000, |bad_s} + {4'b0000, close_s};
    case (state_r)
      IDLE: begin
        if (tick_d_r) begin
          target_s = row;
          mask_s   = 4'b0000;
          state_s  = PLAY;
        end else begin
          state_s  = IDLE;
        end
      end
      PLAY: begin
        hit_s  = |good_s;
        miss_s = (|bad_s) | close_s;
        if (score_sum_s > SCORE_TOP) begin
          score_s = {SCORE_W{1'b1}};
        end else begin
          score_s = score_sum_s[SCORE_W-1:0];
        end
        if (miss_sum_s >= MISS_LIMIT) begin
          misses_s = MISS_LIMIT[3:0];
          state_s  = OVER;
        end else begin
          misses_s = miss_sum_s[3:0];
        end
        if (tick_d_r) begin
          target_s = row;
          mask_s   = 4'b0000;
        end else begin
          mask_s   = mask_r | good_s;
        end
      end
      OVER: begin
        state_s = OVER;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // game state and registered outputs
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      mask_r      <= 4'b0000;
      target_r    <= 4'b0000;
      score_r     <= {SCORE_W{1'b0}};
      misses_r    <= 4'b0000;
      hit_r       <= 1'b0;
      miss_r      <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      mask_r      <= mask_s;
      target_r    <= target_s;
      score_r     <= score_s;
      misses_r    <= misses_s;
      hit_r       <= hit_s;
      miss_r      <= miss_s;
      game_over_r <= (state_s == OVER);
    end
  end

  assign score     = score_r;
  assign misses    = misses_r;
  assign hit       = hit_r;
  assign miss      = miss_r;
  assign game_over = game_over_r;
  assign target    = target_r;

endmodule

// File: tb/tb_tile_hit_judge.sv
// Bench for tile_hit_judge: directed game scenarios plus random play, checked
// every cycle against a window/score model; SCORE_W=8 and SCORE_W=2 run side by side.
module tb_tile_hit_judge;

  localparam int MAXM = 3;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [3:0] row;
  logic [3:0] key_n;

  logic [7:0] score8;
  logic [1:0] score2;
  logic [3:0] misses8, misses2, target8, target2;
  logic       hit8, hit2, miss8, miss2, go8, go2;

  int n_cmp = 0;
  int n_bad = 0;

  tile_hit_judge #(.SCORE_W(8), .MAX_MISSES(MAXM)) u_dut8 (
    .CLOCK_50(clk), .reset(reset), .tick(tick), .row(row), .key_n(key_n),
    .score(score8), .misses(misses8), .hit(hit8), .miss(miss8),
    .game_over(go8), .target(target8)
  );

  tile_hit_judge #(.SCORE_W(2), .MAX_MISSES(MAXM)) u_dut2 (
    .CLOCK_50(clk), .reset(reset), .tick(tick), .row(row), .key_n(key_n),
    .score(score2), .misses(misses2), .hit(hit2), .miss(miss2),
    .game_over(go2), .target(target2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       started;
    logic       over;
    logic [3:0] tgt;
    logic [3:0] claimed;
    int         total;
    int         nmiss;
    logic       hit;
    logic       miss;
  } mstate_t;

  mstate_t m;
  logic [3:0] k1, k2, k3, k4;
  logic       t1;

  function automatic mstate_t idle_state();
    mstate_t s;
    s.started = 1'b0; s.over = 1'b0; s.tgt = 4'd0; s.claimed = 4'd0;
    s.total = 0; s.nmiss = 0; s.hit = 1'b0; s.miss = 1'b0;
    return s;
  endfunction

  // one clock of the game, from the rules: press/tick effects judged per window
  function automatic mstate_t advance(mstate_t s, logic [3:0] press, logic tk, logic [3:0] r);
    mstate_t n = s;
    logic [3:0] good;
    int inc;
    n.hit = 1'b0;
    n.miss = 1'b0;
    if (!s.over && !s.started) begin
      if (tk) begin
        n.started = 1'b1; n.tgt = r; n.claimed = 4'd0;
      end
    end else if (!s.over) begin
      good = press & s.tgt & ~s.claimed;
      for (int c = 0; c < 4; c++) if (good[c]) n.total++;
      inc = 0;
      if ((press & ~good) != 4'd0) inc++;
      if (tk && s.tgt != 4'd0 && ((s.claimed | good) != s.tgt)) inc++;
      n.nmiss = s.nmiss + inc;
      if (n.nmiss >= MAXM) begin
        n.nmiss = MAXM; n.over = 1'b1;
      end
      n.hit = (good != 4'd0);
      n.miss = (inc != 0);
      n.claimed = s.claimed | good;
      if (tk) begin
        n.tgt = r; n.claimed = 4'd0;
      end
    end
    return n;
  endfunction

  function automatic int sat(int v, int top);
    return (v > top) ? top : v;
  endfunction

  // reference model: a key sampled low 3 edges ago (released 4 ago) is a press now
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k1 <= 4'hF; k2 <= 4'hF; k3 <= 4'hF; k4 <= 4'hF; t1 <= 1'b0;
      m <= idle_state();
    end else begin
      m  <= advance(m, ~k3 & k4, t1, row);
      k1 <= key_n; k2 <= k1; k3 <= k2; k4 <= k3;
      t1 <= tick;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (reset) begin
      check("score8", score8, sat(m.total, 255));
      check("score2", score2, sat(m.total, 3));
      check("misses8", misses8, m.nmiss);
      check("misses2", misses2, m.nmiss);
      check("hit8", hit8, m.hit);
      check("hit2", hit2, m.hit);
      check("miss8", miss8, m.miss);
      check("miss2", miss2, m.miss);
      check("game_over8", go8, m.over);
      check("game_over2", go2, m.over);
      check("target8", target8, m.tgt);
      check("target2", target2, m.tgt);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_tick(input logic [3:0] r);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    row  = r;
    step(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_score8"}, score8, 0);
    check({tag, "_score2"}, score2, 0);
    check({tag, "_misses"}, misses8, 0);
    check({tag, "_hit"}, hit8, 0);
    check({tag, "_miss"}, miss8, 0);
    check({tag, "_game_over"}, go8, 0);
    check({tag, "_target"}, target8, 0);
  endtask

  task automatic pulse_reset(input bit chk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    if (chk) check_all_zero("midrst");
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic pin(input string tag, input int sc, input int ms, input int go, input int tg);
    check({tag, "_score"}, score8, sc);
    check({tag, "_score_sat2"}, score2, sat(sc, 3));
    check({tag, "_misses"}, misses8, ms);
    check({tag, "_game_over"}, go8, go);
    check({tag, "_target"}, target8, tg);
    check({tag, "_model_total"}, m.total, sc);
    check({tag, "_model_misses"}, m.nmiss, ms);
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; row = 4'd0; key_n = 4'hF;
    step(3);
    check_all_zero("reset");
    #1 reset = 1'b1;
    step(2);

    // window 1 empty, window 2 holds col1; hit it
    do_tick(4'b0000);
    do_tick(4'b1000);
    key_n = 4'b0111; step(2); key_n = 4'b1111; step(5);
    pin("t1", 1, 0, 0, 8);

    // 1000 window closes satisfied, 0100 window closes unpressed
    do_tick(4'b0100);
    do_tick(4'b1010);
    step(2);
    pin("t2", 1, 1, 0, 10);

    // double hit, then col1 held across three windows
    key_n = 4'b0101; step(1);
    key_n = 4'b0111; step(5);
    do_tick(4'b0000); step(3);
    do_tick(4'b0000); step(3);
    do_tick(4'b0000); step(3);
    key_n = 4'b1111; step(5);
    pin("t3", 3, 1, 0, 0);

    // wrong column, then a press landing in the tick_d cycle
    do_tick(4'b0001);
    key_n = 4'b1011; step(2); key_n = 4'b1111; step(5);
    pin("t4a", 3, 2, 0, 1);
    key_n = 4'b1110; step(2);
    tick = 1'b1; step(1);
    tick = 1'b0; row = 4'b0000; step(2);
    key_n = 4'b1111; step(4);
    pin("t4b", 4, 2, 0, 0);

    // third miss ends the game; afterwards everything is frozen
    do_tick(4'b1000); step(2);
    do_tick(4'b0000); step(2);
    pin("t5a", 4, 3, 1, 0);
    key_n = 4'b0000; step(3); key_n = 4'b1111; step(2);
    do_tick(4'b1111); step(2);
    do_tick(4'b1111); step(2);
    pin("t5b", 4, 3, 1, 0);
    pulse_reset(1'b1);
    step(2);

    // random play over many short games
    for (int g = 0; g < 20; g++) begin
      for (int cyc = 0; cyc < 300; cyc++) begin
        tick = ($urandom_range(0, 5) == 0);
        row  = 4'($urandom_range(0, 15));
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(0, 3) == 0) key_n[c] = ~key_n[c];
        end
        step(1);
      end
      tick = 1'b0;
      key_n = 4'hF;
      pulse_reset(g[0]);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
